multicycle_sequencer: RTL

- Multi-cycle FSM that sequences the RV32I datapath: instruction fetch, decode, execute, data-memory access and register writeback.
- Sits beside the combinational decode/ALU-control logic. Issues per-phase write strobes (IR, PC, register file) and valid/ready-style memory requests.
- Counts retired instructions.
- Detects memory timeouts and latches a sticky bus error.

---
 rtl/riscv_ctrl_pkg.sv | 33 +++
 rtl/mem_timeout_ctr.sv | 27 ++
 rtl/multicycle_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the RV32I multi-cycle control path: opcodes, sequencer states and
// PC source encodings.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StErr    = 3'd6,
    StTrap   = 3'd7
  } state_e;

  localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
  localparam logic [1:0] PC_SEL_REL   = 2'b01;
  localparam logic [1:0] PC_SEL_JALR  = 2'b10;
  localparam logic [1:0] PC_SEL_TRAP  = 2'b11;

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter shared by the fetch and data-memory phases; flags the cycle in which
// the wait would reach the limit.
module mem_timeout_ctr #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] limit,
  output logic             expired
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A zero limit disables the timeout entirely.
  assign expired = enable && (limit != '0) && (cnt_q == limit - 1'b1);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer with retire counter and sticky memory timeout.
// Define ILLEGAL_TRAP_EN to send illegal opcodes through a one-cycle trap state.
module multicycle_sequencer
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RETIRE_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run_en,
  input  logic [6:0]          opcode,
  input  logic                branch_cond,
  output logic                imem_req,
  input  logic                imem_ready,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ready,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic                rf_we,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] instret,
  output logic                bus_err,
  output logic                halted
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  logic [RETIRE_W-1:0] instret_q;
  logic                bus_err_q;
  logic                retire;
  logic                wait_en;
  logic                wait_clear;
  logic                expired;

  // Kept outside the FSM block so the expiry path has no combinational loop.
  assign wait_en = ((state_q == StFetch) && !imem_ready) || ((state_q == StMem) && !dmem_ready);
  assign wait_clear = (state_d != state_q) && ((state_d == StFetch) || (state_d == StMem));

  mem_timeout_ctr #(
    .Width (CntW)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (wait_clear),
    .enable  (wait_en),
    .limit   (Limit),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      instret_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + 1'b1;
      if (state_d == StErr) bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_SEL_PLUS4;
    rf_we    = 1'b0;
    retire   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run_en) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end else if (expired) begin
          state_d = StErr;
        end
      end
      StDecode: begin
        if (is_legal(opcode)) begin
          state_d = StExec;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = StTrap;
`else
          state_d = StWb;
`endif
        end
      end
      StExec: begin
        if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
          state_d = StMem;
        end else if (opcode == OP_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = branch_cond ? PC_SEL_REL : PC_SEL_PLUS4;
          retire = 1'b1;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        if (dmem_ready) begin
          if (opcode == OP_STORE) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end else begin
            state_d = StWb;
          end
        end else if (expired) begin
          state_d = StErr;
        end
      end
      StWb: begin
        pc_we  = 1'b1;
        rf_we  = is_legal(opcode);  // illegal opcodes retire as a NOP
        retire = 1'b1;
        if (opcode == OP_JAL) begin
          pc_sel = PC_SEL_REL;
        end else if (opcode == OP_JALR) begin
          pc_sel = PC_SEL_JALR;
        end
      end
      StErr: begin
        state_d = StErr;
      end
      StTrap: begin
`ifdef ILLEGAL_TRAP_EN
        pc_we   = 1'b1;
        pc_sel  = PC_SEL_TRAP;
        state_d = run_en ? StFetch : StIdle;
`else
        state_d = StIdle;
`endif
      end
    endcase

    if (retire) state_d = run_en ? StFetch : StIdle;

    // Reset aborts the instruction: no architectural update in the reset cycle.
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = PC_SEL_PLUS4;
      rf_we    = 1'b0;
      retire   = 1'b0;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;
  assign bus_err = bus_err_q;
  assign halted  = (state_q == StIdle) || (state_q == StErr);

endmodule
